// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM controller.
//
// Contents:
//   state_e      - controller FSM states (CLEAR after reset, RUN afterwards)
//   RDW_OLD/NEW  - same-address read-during-write result selection
//   num_lanes    - number of byte lanes in a data word
//   byte_parity  - even-parity bit for one byte
//
// Optional feature macro: DUAL_PORT_RAM_PARITY_EN (consumers only).

package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int num_lanes(input int dataWidth);
    return dataWidth / 8;
  endfunction

  // Parity bit that makes the 9-bit group (byte + parity) contain an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dpram_array.sv
// Storage array for the dual-port RAM controller: one byte-enabled write port
// and one registered (synchronous) read port. Writes or reads outside DEPTH
// are dropped / return zero.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (read register only)
//   we_i, waddr_i      write request and address
//   wbe_i, wdata_i     byte-lane enables and write data
//   wpar_i             per-byte parity to store (DUAL_PORT_RAM_PARITY_EN only)
//   re_i, raddr_i      read request and address
//   rdata_o            registered read data, holds between reads
//   rpar_o             registered stored parity (DUAL_PORT_RAM_PARITY_EN only)

module dpram_array
  import dpram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [ADDR_WIDTH-1:0]      waddr_i,
  input  logic [DATA_WIDTH/8-1:0]    wbe_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       re_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
`ifdef DUAL_PORT_RAM_PARITY_EN
  ,
  input  logic [DATA_WIDTH/8-1:0]    wpar_i,
  output logic [DATA_WIDTH/8-1:0]    rpar_o
`endif
);

  localparam int NB = num_lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign wr_in_range = int'(waddr_i) < DEPTH;
  assign rd_in_range = int'(raddr_i) < DEPTH;

  // Storage has no reset; the controller's clear sequence initialises it.
  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Read register sees the pre-write word on a same-address collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_in_range ? mem[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [NB-1:0] pmem [DEPTH];
  logic [NB-1:0] rpar_q;

  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) pmem[waddr_i][b] <= wpar_i[b];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpar_q <= '0;
    end else if (re_i) begin
      rpar_q <= rd_in_range ? pmem[raddr_i] : '0;
    end
  end

  assign rpar_o = rpar_q;
`endif

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Simple dual-port RAM controller: one write port, one read port, byte
// enables, 1- or 2-cycle read latency and a hardware clear after every reset.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ready_o                  clear finished, requests are accepted
//   wr_en_i/wr_addr_i/wr_be_i/wr_data_i   write request
//   rd_en_i/rd_addr_i        read request
//   rd_data_o, rd_valid_o    read result, valid for one cycle RD_LAT after accept
//   par_inject_i, par_err_o  parity test/check (DUAL_PORT_RAM_PARITY_EN only)
//
// Optional feature macro: DUAL_PORT_RAM_PARITY_EN adds per-byte even parity.

module dual_port_ram_ctrl
  import dpram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    ready_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o
`ifdef DUAL_PORT_RAM_PARITY_EN
  ,
  input  logic                    par_inject_i,
  output logic                    par_err_o
`endif
);

  localparam int NB = num_lanes(DATA_WIDTH);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  ready_q;

  logic                  clearing;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  coll_hit;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [NB-1:0]         arr_wbe;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  logic                  v1_q;
  logic [NB-1:0]         coll_be_q;
  logic [DATA_WIDTH-1:0] coll_data_q;
  logic [DATA_WIDTH-1:0] s1_data;

  // Clear sequencer: one zero write per cycle, then RUN until the next reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign clearing = (state_q == CLEAR);
  assign wr_acc   = ready_q & wr_en_i;
  assign rd_acc   = ready_q & rd_en_i;

  assign arr_we    = clearing | wr_acc;
  assign arr_waddr = clearing ? clr_addr_q : wr_addr_i;
  assign arr_wbe   = clearing ? {NB{1'b1}} : wr_be_i;
  assign arr_wdata = clearing ? '0 : wr_data_i;

  // Only an in-range same-address write can be merged into the read result.
  assign coll_hit = (RDW_MODE == RDW_NEW) && wr_acc && (wr_addr_i == rd_addr_i) &&
                    (int'(rd_addr_i) < DEPTH);

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [NB-1:0] arr_wpar;
  logic [NB-1:0] arr_rpar;
  logic [NB-1:0] coll_par_q;
  logic [NB-1:0] s1_par;
  logic          s1_err;

  always_comb begin
    arr_wpar = '0;
    if (!clearing) begin
      for (int b = 0; b < NB; b++) begin
        arr_wpar[b] = byte_parity(wr_data_i[b*8 +: 8]) ^ par_inject_i;
      end
    end
  end
`endif

  dpram_array #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wbe_i   (arr_wbe),
    .wdata_i (arr_wdata),
    .re_i    (rd_acc),
    .raddr_i (rd_addr_i),
    .rdata_o (arr_rdata)
`ifdef DUAL_PORT_RAM_PARITY_EN
    ,
    .wpar_i  (arr_wpar),
    .rpar_o  (arr_rpar)
`endif
  );

  // First read stage: captures the collision bytes alongside the array read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q        <= 1'b0;
      coll_be_q   <= '0;
      coll_data_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        coll_be_q   <= coll_hit ? wr_be_i : '0;
        coll_data_q <= wr_data_i;
      end
    end
  end

  always_comb begin
    s1_data = arr_rdata;
    for (int b = 0; b < NB; b++) begin
      if (coll_be_q[b]) s1_data[b*8 +: 8] = coll_data_q[b*8 +: 8];
    end
  end

`ifdef DUAL_PORT_RAM_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_par_q <= '0;
    end else if (rd_acc) begin
      coll_par_q <= arr_wpar;
    end
  end

  always_comb begin
    s1_par = arr_rpar;
    s1_err = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (coll_be_q[b]) s1_par[b] = coll_par_q[b];
      if (byte_parity(s1_data[b*8 +: 8]) != s1_par[b]) s1_err = 1'b1;
    end
  end
`endif

  // Optional second stage adds an output register behind the array read.
  if (RD_LAT == 2) begin : g_lat2
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= s1_data;
      end
    end

    assign rd_valid_o = v2_q;
    assign rd_data_o  = d2_q;

`ifdef DUAL_PORT_RAM_PARITY_EN
    logic err2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err2_q <= 1'b0;
      else         err2_q <= v1_q & s1_err;
    end

    assign par_err_o = err2_q;
`endif
  end else begin : g_lat1
    assign rd_valid_o = v1_q;
    assign rd_data_o  = s1_data;
`ifdef DUAL_PORT_RAM_PARITY_EN
    assign par_err_o  = v1_q & s1_err;
`endif
  end

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Directed testbench for dual_port_ram_ctrl. Four instances share one set of
// inputs: A (RD_LAT=1, old-data collisions), B (RD_LAT=1, merged collisions),
// C (RD_LAT=2, old-data collisions) and D (DEPTH=12, RD_LAT=1) for the
// out-of-range address behaviour. DUAL_PORT_RAM_PARITY_EN enables the parity vectors.

module tb_dual_port_ram_ctrl;

  logic        clock;
  logic        resetN;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [3:0]  wrBe;
  logic [31:0] wrData;
  logic        rdEn;
  logic [3:0]  rdAddr;

  logic        readyA, readyB, readyC, readyD;
  logic        validA, validB, validC, validD;
  logic [31:0] dataA, dataB, dataC, dataD;

  int vectorCount = 0;
  int miscompares = 0;

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic parInject;
  logic parErrA, parErrB, parErrC, parErrD;
`endif

  dual_port_ram_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LAT(1), .RDW_MODE(0)) dutA (
    .clk_i(clock), .rst_ni(resetN), .ready_o(readyA),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_be_i(wrBe), .wr_data_i(wrData),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .rd_data_o(dataA), .rd_valid_o(validA)
`ifdef DUAL_PORT_RAM_PARITY_EN
    , .par_inject_i(parInject), .par_err_o(parErrA)
`endif
  );

  dual_port_ram_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LAT(1), .RDW_MODE(1)) dutB (
    .clk_i(clock), .rst_ni(resetN), .ready_o(readyB),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_be_i(wrBe), .wr_data_i(wrData),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .rd_data_o(dataB), .rd_valid_o(validB)
`ifdef DUAL_PORT_RAM_PARITY_EN
    , .par_inject_i(parInject), .par_err_o(parErrB)
`endif
  );

  dual_port_ram_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LAT(2), .RDW_MODE(0)) dutC (
    .clk_i(clock), .rst_ni(resetN), .ready_o(readyC),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_be_i(wrBe), .wr_data_i(wrData),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .rd_data_o(dataC), .rd_valid_o(validC)
`ifdef DUAL_PORT_RAM_PARITY_EN
    , .par_inject_i(parInject), .par_err_o(parErrC)
`endif
  );

  dual_port_ram_ctrl #(.DEPTH(12), .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LAT(1), .RDW_MODE(0)) dutD (
    .clk_i(clock), .rst_ni(resetN), .ready_o(readyD),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_be_i(wrBe), .wr_data_i(wrData),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .rd_data_o(dataD), .rd_valid_o(validD)
`ifdef DUAL_PORT_RAM_PARITY_EN
    , .par_inject_i(parInject), .par_err_o(parErrD)
`endif
  );

  // Free-running 10 ns clock; stimulus and sampling both happen on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wEn, input logic [3:0] wAddr, input logic [3:0] wBe,
                               input logic [31:0] wData, input logic rEn, input logic [3:0] rAddr);
    wrEn   = wEn;
    wrAddr = wAddr;
    wrBe   = wBe;
    wrData = wData;
    rdEn   = rEn;
    rdAddr = rAddr;
  endtask

  // Waits for both clear lengths after reset release; optionally keeps requests
  // asserted for the first ten cycles to prove they are ignored.
  task automatic waitForReady(input string tag, input bit driveRequests);
    int readyAt16 = 0;
    int readyAt12 = 0;
    bit sawValid = 0;
    if (driveRequests) applyStimulus(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b1, 4'd3);
    resetN = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      if (i == 10) applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
      if (validA || validB || validC || validD) sawValid = 1;
      if (readyA && readyAt16 == 0) readyAt16 = i;
      if (readyD && readyAt12 == 0) readyAt12 = i;
      if (readyAt16 != 0 && readyAt12 != 0) break;
    end
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput({tag, " clear cycles D16"}, 32'(readyAt16), 32'd16);
    checkOutput({tag, " clear cycles D12"}, 32'(readyAt12), 32'd12);
    checkOutput({tag, " no valid in clear"}, {31'd0, sawValid}, 32'd0);
  endtask

  // Write one word; returns on the falling edge after the accepting rising edge.
  task automatic doWrite(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
    applyStimulus(1'b1, addr, be, data, 1'b0, 4'd0);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
  endtask

  // Single read: checks the 1-cycle instances, then the 2-cycle one and the hold of A.
  task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] expA,
                           input logic [31:0] expB, input logic [31:0] expD);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, addr);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput({tag, " validA"}, {31'd0, validA}, 32'd1);
    checkOutput({tag, " dataA"}, dataA, expA);
    checkOutput({tag, " dataB"}, dataB, expB);
    checkOutput({tag, " validD"}, {31'd0, validD}, 32'd1);
    checkOutput({tag, " dataD"}, dataD, expD);
    checkOutput({tag, " validC early"}, {31'd0, validC}, 32'd0);
    @(negedge clock);
    checkOutput({tag, " validC"}, {31'd0, validC}, 32'd1);
    checkOutput({tag, " dataC"}, dataC, expA);
    checkOutput({tag, " validA drop"}, {31'd0, validA}, 32'd0);
    checkOutput({tag, " dataA hold"}, dataA, expA);
  endtask

  // Main directed sequence.
  initial begin
    resetN = 1'b0;
`ifdef DUAL_PORT_RAM_PARITY_EN
    parInject = 1'b0;
`endif
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    repeat (3) @(negedge clock);

    checkOutput("reset ready", {31'd0, readyA}, 32'd0);
    checkOutput("reset valid", {31'd0, validA | validC}, 32'd0);
    checkOutput("reset dataA", dataA, 32'h0);
    checkOutput("reset dataC", dataC, 32'h0);

    waitForReady("boot", 1'b1);

    for (int a = 0; a < 16; a++) begin
      readCheck($sformatf("clear addr%0d", a), 4'(a), 32'h0, 32'h0, 32'h0);
    end

    doWrite(4'd5, 4'hF, 32'h11223344);
    doWrite(4'd5, 4'b0101, 32'hAABBCCDD);
    readCheck("byte enables", 4'd5, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    doWrite(4'd5, 4'h0, 32'hFFFFFFFF);
    readCheck("be zero", 4'd5, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    doWrite(4'd13, 4'hF, 32'h12345678);
    readCheck("out of range", 4'd13, 32'h12345678, 32'h12345678, 32'h0);

    applyStimulus(1'b1, 4'd7, 4'hF, 32'hCAFEF00D, 1'b1, 4'd7);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput("collision old A", dataA, 32'h0);
    checkOutput("collision new B", dataB, 32'hCAFEF00D);
    checkOutput("collision valid B", {31'd0, validB}, 32'd1);
    @(negedge clock);
    checkOutput("collision old C", dataC, 32'h0);
    readCheck("rd after wr", 4'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

    applyStimulus(1'b1, 4'd5, 4'b1000, 32'h99887766, 1'b1, 4'd5);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput("partial coll A", dataA, 32'h11BB33DD);
    checkOutput("partial coll B", dataB, 32'h99BB33DD);
    @(negedge clock);

    applyStimulus(1'b1, 4'd8, 4'hF, 32'h0BADF00D, 1'b1, 4'd5);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput("diff addr A", dataA, 32'h99BB33DD);
    checkOutput("diff addr B", dataB, 32'h99BB33DD);
    @(negedge clock);
    readCheck("diff addr wr", 4'd8, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D);

    doWrite(4'd0, 4'hF, 32'h10000000);
    doWrite(4'd1, 4'hF, 32'h10000001);
    doWrite(4'd2, 4'hF, 32'h10000002);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0);
    @(negedge clock);
    checkOutput("pipe +1 A", dataA, 32'h10000000);
    checkOutput("pipe +1 C valid", {31'd0, validC}, 32'd0);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd1);
    @(negedge clock);
    checkOutput("pipe +2 A", dataA, 32'h10000001);
    checkOutput("pipe +2 C valid", {31'd0, validC}, 32'd1);
    checkOutput("pipe +2 C", dataC, 32'h10000000);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput("pipe +3 A", dataA, 32'h10000002);
    checkOutput("pipe +3 C valid", {31'd0, validC}, 32'd1);
    checkOutput("pipe +3 C", dataC, 32'h10000001);
    @(negedge clock);
    checkOutput("pipe +4 C valid", {31'd0, validC}, 32'd1);
    checkOutput("pipe +4 C", dataC, 32'h10000002);
    checkOutput("pipe +4 A valid", {31'd0, validA}, 32'd0);
    @(negedge clock);
    checkOutput("pipe +5 C valid", {31'd0, validC}, 32'd0);

`ifdef DUAL_PORT_RAM_PARITY_EN
    parInject = 1'b1;
    doWrite(4'd9, 4'hF, 32'h000000FF);
    parInject = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput("parity inject err", {31'd0, parErrA & validA}, 32'd1);
    @(negedge clock);
    checkOutput("parity inject err C", {31'd0, parErrC & validC}, 32'd1);
    doWrite(4'd9, 4'hF, 32'h000000FF);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    checkOutput("parity clean valid", {31'd0, validA}, 32'd1);
    checkOutput("parity clean err", {31'd0, parErrA}, 32'd0);
    @(negedge clock);
    checkOutput("parity clean err C", {31'd0, parErrC}, 32'd0);
`endif

    // Reset lands while the 2-cycle read is still in flight.
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd1);
    @(negedge clock);
    applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    resetN = 1'b0;
    @(negedge clock);
    checkOutput("midreset valid C", {31'd0, validC}, 32'd0);
    checkOutput("midreset ready", {31'd0, readyA}, 32'd0);
    checkOutput("midreset dataA", dataA, 32'h0);
    @(negedge clock);
    checkOutput("midreset valid C late", {31'd0, validC}, 32'd0);
    waitForReady("rereset", 1'b0);
    readCheck("recleared addr1", 4'd1, 32'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
